dc_scan_ctrl: RTL and testbench

//  Sequencer for the digital_core shift chain. Accepts a CHAIN_LEN-bit load

---
 rtl/dc_scan_ctrl.sv | 174 +++++++++++++++++
 tb/tb_dc_scan_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_scan_ctrl.sv
// Shift-chain sequencer for digital_core: serially loads a word through
// dc_clk_enable pulses and returns the previous chain contents.
// Optional build macro DC_SCAN_COMPARE_EN adds an expected-data compare.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once valid is raised, the sender holds valid and data stable
// until that edge.
module dc_scan_ctrl #(
  parameter int CHAIN_LEN = 3,
  parameter int DIV_W     = 8
) (
  input  logic                 internal_clk,
  input  logic                 sc_rstn,
  input  logic                 sc_req_valid,
  output logic                 sc_req_ready,
  input  logic [CHAIN_LEN-1:0] sc_req_data,
  input  logic [DIV_W-1:0]     sc_div,
  input  logic                 sc_abort,
  output logic                 sc_rsp_valid,
  input  logic                 sc_rsp_ready,
  output logic [CHAIN_LEN-1:0] sc_rsp_data,
  output logic                 sc_busy,
  output logic                 dc_clk_enable,
  output logic                 dc_digital_input,
  input  logic                 dc_digital_output
`ifdef DC_SCAN_COMPARE_EN
  ,
  input  logic [CHAIN_LEN-1:0] sc_exp_data,
  output logic                 sc_mismatch
`endif
);

  localparam int BW = (CHAIN_LEN < 2) ? 1 : $clog2(CHAIN_LEN + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [CHAIN_LEN-1:0] tx_sr, tx_sr_n;
  logic [CHAIN_LEN-1:0] cap_sr, cap_sr_n;
  logic [DIV_W-1:0]     div_q, div_q_n;
  logic [DIV_W-1:0]     div_cnt, div_cnt_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic                 en_q, en_n;
  logic                 din_q, din_n;
  logic                 rsp_valid_q, rsp_valid_n;
  logic [CHAIN_LEN-1:0] rsp_data_q, rsp_data_n;
`ifdef DC_SCAN_COMPARE_EN
  logic [CHAIN_LEN-1:0] exp_q, exp_n;
  logic                 mis_q, mis_n;
`endif

  // en_q is the registered pulse: it is high exactly in cycles where the
  // divider counter sits at zero, so the next values are computed one cycle
  // ahead from the counter's next value.
  always_comb begin
    state_n     = state;
    tx_sr_n     = tx_sr;
    cap_sr_n    = cap_sr;
    div_q_n     = div_q;
    div_cnt_n   = div_cnt;
    bit_cnt_n   = bit_cnt;
    en_n        = 1'b0;
    din_n       = 1'b0;
    rsp_valid_n = 1'b0;
    rsp_data_n  = rsp_data_q;
`ifdef DC_SCAN_COMPARE_EN
    exp_n       = exp_q;
    mis_n       = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (sc_req_valid) begin
          state_n   = SHIFT;
          tx_sr_n   = sc_req_data;
          div_q_n   = sc_div;
          div_cnt_n = sc_div;
          bit_cnt_n = '0;
          cap_sr_n  = '0;
          en_n      = (sc_div == '0);
          din_n     = sc_req_data[CHAIN_LEN-1];
`ifdef DC_SCAN_COMPARE_EN
          exp_n     = sc_exp_data;
`endif
        end
      end
      SHIFT: begin
        if (sc_abort) begin
          state_n = IDLE;
        end else if (en_q) begin
          cap_sr_n  = (cap_sr << 1) | CHAIN_LEN'(dc_digital_output);
          tx_sr_n   = tx_sr << 1;
          bit_cnt_n = bit_cnt + BW'(1);
          div_cnt_n = div_q;
          if (bit_cnt == LAST_BIT) begin
            state_n     = DONE;
            rsp_valid_n = 1'b1;
            rsp_data_n  = cap_sr_n;
`ifdef DC_SCAN_COMPARE_EN
            mis_n       = (cap_sr_n != exp_q);
`endif
          end else begin
            en_n  = (div_q == '0);
            din_n = tx_sr_n[CHAIN_LEN-1];
          end
        end else begin
          div_cnt_n = div_cnt - DIV_W'(1);
          en_n      = (div_cnt == DIV_W'(1));
          din_n     = tx_sr[CHAIN_LEN-1];
        end
      end
      DONE: begin
        if (sc_rsp_ready) begin
          state_n = IDLE;
        end else begin
          rsp_valid_n = 1'b1;
`ifdef DC_SCAN_COMPARE_EN
          mis_n       = mis_q;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge internal_clk or negedge sc_rstn) begin
    if (!sc_rstn) begin
      state       <= IDLE;
      tx_sr       <= '0;
      cap_sr      <= '0;
      div_q       <= '0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      en_q        <= 1'b0;
      din_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef DC_SCAN_COMPARE_EN
      exp_q       <= '0;
      mis_q       <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      tx_sr       <= tx_sr_n;
      cap_sr      <= cap_sr_n;
      div_q       <= div_q_n;
      div_cnt     <= div_cnt_n;
      bit_cnt     <= bit_cnt_n;
      en_q        <= en_n;
      din_q       <= din_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_data_q  <= rsp_data_n;
`ifdef DC_SCAN_COMPARE_EN
      exp_q       <= exp_n;
      mis_q       <= mis_n;
`endif
    end
  end

  assign sc_req_ready     = (state == IDLE);
  assign sc_busy          = (state != IDLE);
  assign dc_clk_enable    = en_q;
  assign dc_digital_input = din_q;
  assign sc_rsp_valid     = rsp_valid_q;
  assign sc_rsp_data      = rsp_data_q;
`ifdef DC_SCAN_COMPARE_EN
  assign sc_mismatch      = mis_q;
`endif

endmodule

// File: tb/tb_dc_scan_ctrl.sv
// Directed bench for dc_scan_ctrl with a 3-bit behavioural digital_core chain.
// Define DC_SCAN_COMPARE_EN for both files to exercise the compare option.
module tb_dc_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_data = '0;
  logic [7:0] sc_div = '0;
  logic       sc_abort = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [2:0] rsp_data;
  logic       busy;
  logic       dc_en;
  logic       dc_din;
  logic       dc_dout;
  logic [2:0] core = '0;
`ifdef DC_SCAN_COMPARE_EN
  logic [2:0] exp_data = '0;
  logic       mismatch;
`endif

  int n_pass = 0;
  int n_total = 0;

  dc_scan_ctrl #(.CHAIN_LEN(3), .DIV_W(8)) dut (
    .internal_clk      (clk),
    .sc_rstn           (rst_n),
    .sc_req_valid      (req_valid),
    .sc_req_ready      (req_ready),
    .sc_req_data       (req_data),
    .sc_div            (sc_div),
    .sc_abort          (sc_abort),
    .sc_rsp_valid      (rsp_valid),
    .sc_rsp_ready      (rsp_ready),
    .sc_rsp_data       (rsp_data),
    .sc_busy           (busy),
    .dc_clk_enable     (dc_en),
    .dc_digital_input  (dc_din),
    .dc_digital_output (dc_dout)
`ifdef DC_SCAN_COMPARE_EN
    ,
    .sc_exp_data       (exp_data),
    .sc_mismatch       (mismatch)
`endif
  );

  always #5 clk = ~clk;

  // digital_core model: MSB leaves first, new bit enters at LSB
  always @(posedge clk) if (dc_en) core <= {core[1:0], dc_din};
  assign dc_dout = core[2];

  // Called at a negedge with the DUT idle; returns at the negedge where
  // rsp_valid is first seen. n counts negedges after the accept edge.
  task automatic run_op(input logic [2:0] data, input logic [7:0] div,
                        output logic [2:0] rsp, output int valid_n,
                        output logic [63:0] pmask);
    pmask = '0;
    valid_n = -1;
    rsp = '0;
    req_valid = 1'b1;
    req_data = data;
    sc_div = div;
    @(negedge clk);
    req_valid = 1'b0;
    req_data = 3'b111;
    sc_div = 8'hff;
    for (int n = 1; n < 200; n++) begin
      if (dc_en && n < 64) pmask[n] = 1'b1;
      if (rsp_valid) begin
        valid_n = n;
        rsp = rsp_data;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_total++;
    if ({req_ready, busy, dc_en, dc_din, rsp_valid, rsp_data} !== 8'b1000_0000)
      $display("FAIL reset_outputs: got %b want 10000000",
               {req_ready, busy, dc_en, dc_din, rsp_valid, rsp_data});
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if ({req_ready, busy, dc_en, rsp_valid} !== 4'b1000)
      $display("FAIL reset_release: got %b want 1000", {req_ready, busy, dc_en, rsp_valid});
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [2:0] rsp; int vn; logic [63:0] pm;
    rsp_ready = 1'b1;
    run_op(3'b101, 8'd0, rsp, vn, pm);
    n_total++;
    if (pm !== 64'b1110) $display("FAIL basic_pulses: got %h want %h", pm, 64'b1110);
    else n_pass++;
    n_total++;
    if (vn !== 4) $display("FAIL basic_latency: got %0d want 4", vn);
    else n_pass++;
    n_total++;
    if (rsp !== 3'b000) $display("FAIL basic_rsp: got %b want 000", rsp);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({req_ready, rsp_valid, dc_en, dc_din} !== 4'b1000)
      $display("FAIL basic_idle: got %b want 1000", {req_ready, rsp_valid, dc_en, dc_din});
    else n_pass++;
    n_total++;
    if (core !== 3'b101) $display("FAIL basic_core: got %b want 101", core);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] rsp; int vn; logic [63:0] pm;
    run_op(3'b011, 8'd0, rsp, vn, pm);
    n_total++;
    if (rsp !== 3'b101 || vn !== 4) $display("FAIL b2b_rsp: got %b@%0d want 101@4", rsp, vn);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (core !== 3'b011) $display("FAIL b2b_core: got %b want 011", core);
    else n_pass++;
  endtask

  task automatic test_divider();
    logic [2:0] rsp; int vn; logic [63:0] pm;
    logic [63:0] want;
    want = (64'd1 << 5) | (64'd1 << 10) | (64'd1 << 15);
    run_op(3'b110, 8'd4, rsp, vn, pm);
    n_total++;
    if (pm !== want) $display("FAIL div_pulses: got %h want %h", pm, want);
    else n_pass++;
    n_total++;
    if (vn !== 16) $display("FAIL div_latency: got %0d want 16", vn);
    else n_pass++;
    n_total++;
    if (rsp !== 3'b011) $display("FAIL div_rsp: got %b want 011", rsp);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (core !== 3'b110) $display("FAIL div_core: got %b want 110", core);
    else n_pass++;
  endtask

  task automatic test_hold();
    logic [2:0] rsp; int vn; logic [63:0] pm;
    rsp_ready = 1'b0;
    run_op(3'b001, 8'd1, rsp, vn, pm);
    n_total++;
    if (rsp !== 3'b110 || vn !== 7 || pm !== 64'h54)
      $display("FAIL hold_op: got %b@%0d pulses %h want 110@7 pulses 54", rsp, vn, pm);
    else n_pass++;
    req_valid = 1'b1;
    req_data = 3'b111;
    sc_div = 8'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_total++;
      if ({rsp_valid, rsp_data, req_ready, busy, dc_en} !== 7'b1_110_010)
        $display("FAIL hold_stable[%0d]: got %b want 1110010", i,
                 {rsp_valid, rsp_data, req_ready, busy, dc_en});
      else n_pass++;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if ({req_ready, busy, rsp_valid} !== 3'b100)
      $display("FAIL hold_release: got %b want 100", {req_ready, busy, rsp_valid});
    else n_pass++;
    n_total++;
    if (core !== 3'b001) $display("FAIL hold_core: got %b want 001", core);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [63:0] pm;
    int extra_pulse;
    int extra_valid;
    pm = '0;
    extra_pulse = 0;
    extra_valid = 0;
    req_valid = 1'b1;
    req_data = 3'b010;
    sc_div = 8'd2;
    @(negedge clk);
    req_valid = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      if (dc_en) pm[n] = 1'b1;
      if (n == 4) sc_abort = 1'b1;
      @(negedge clk);
    end
    sc_abort = 1'b0;
    n_total++;
    if ({req_ready, busy, dc_en, dc_din} !== 4'b1000)
      $display("FAIL abort_idle: got %b want 1000", {req_ready, busy, dc_en, dc_din});
    else n_pass++;
    n_total++;
    if (pm !== 64'b1000) $display("FAIL abort_pulses: got %h want 8", pm);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      if (dc_en) extra_pulse++;
      if (rsp_valid) extra_valid++;
      @(negedge clk);
    end
    n_total++;
    if (extra_pulse !== 0 || extra_valid !== 0)
      $display("FAIL abort_quiet: got pulses=%0d valids=%0d want 0/0", extra_pulse, extra_valid);
    else n_pass++;
    n_total++;
    if (core !== 3'b010) $display("FAIL abort_core: got %b want 010", core);
    else n_pass++;
  endtask

`ifdef DC_SCAN_COMPARE_EN
  task automatic test_compare();
    logic [2:0] rsp; int vn; logic [63:0] pm;
    exp_data = 3'b010;
    run_op(3'b100, 8'd0, rsp, vn, pm);
    n_total++;
    if (rsp !== 3'b010 || mismatch !== 1'b0)
      $display("FAIL cmp_match: got %b mis=%b want 010 mis=0", rsp, mismatch);
    else n_pass++;
    @(negedge clk);
    exp_data = 3'b101;
    run_op(3'b101, 8'd1, rsp, vn, pm);
    n_total++;
    if (rsp !== 3'b100 || mismatch !== 1'b1)
      $display("FAIL cmp_mismatch: got %b mis=%b want 100 mis=1", rsp, mismatch);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (mismatch !== 1'b0) $display("FAIL cmp_clear: got %b want 0", mismatch);
    else n_pass++;
  endtask
`endif

  task automatic test_reset_mid();
    int late;
    late = 0;
    req_valid = 1'b1;
    req_data = 3'b111;
    sc_div = 8'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy, dc_en, dc_din} !== 3'b111)
      $display("FAIL rstmid_pre: got %b want 111", {busy, dc_en, dc_din});
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({req_ready, busy, dc_en, dc_din, rsp_valid, rsp_data} !== 8'b1000_0000)
      $display("FAIL rstmid_async: got %b want 10000000",
               {req_ready, busy, dc_en, dc_din, rsp_valid, rsp_data});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid || dc_en || busy) late++;
    end
    n_total++;
    if (late !== 0) $display("FAIL rstmid_quiet: got %0d active cycles want 0", late);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_divider();
    test_hold();
    test_abort();
`ifdef DC_SCAN_COMPARE_EN
    test_compare();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
